// File: rtl/crossbar_rd_rr.sv
// crossbar_rd_rr: NUM_LSU x NUM_BANK read crossbar, per-bank round-robin arbitration, registered in-order returns
module crossbar_rd_rr #(
  parameter int NUM_LSU  = 8,
  parameter int NUM_BANK = 8,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int RD_LAT   = 1,
  parameter int SEL_W    = $clog2(NUM_BANK)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_LSU-1:0]         lsu_req_vld,
  input  logic [NUM_LSU*SEL_W-1:0]   lsu_req_bank,
  input  logic [NUM_LSU*ADDR_W-1:0]  lsu_req_addr,
  output logic [NUM_LSU-1:0]         lsu_req_gnt,
  output logic [NUM_BANK-1:0]        bank_ren,
  output logic [NUM_BANK*ADDR_W-1:0] bank_addr,
  input  logic [NUM_BANK*DATA_W-1:0] bank_rdata,
  output logic [NUM_LSU-1:0]         lsu_rsp_vld,
  output logic [NUM_LSU*DATA_W-1:0]  lsu_rsp_data
);
  localparam int PTR_W = $clog2(NUM_LSU);
  localparam int PID_W = RD_LAT * PTR_W;
  logic [NUM_BANK-1:0][PTR_W-1:0]  ptr_q, ptr_d, win;
  logic [NUM_BANK-1:0]             hit;
  logic [NUM_BANK-1:0][RD_LAT-1:0] pv_q, pv_d;
  logic [NUM_BANK-1:0][PID_W-1:0]  pid_q, pid_d;
  logic [NUM_LSU-1:0]              rsp_vld_d;
  logic [NUM_LSU*DATA_W-1:0]       rsp_data_d;

  // Pass 0 searches indices at/above the pointer, pass 1 wraps to the lowest requester.
  always_comb begin
    lsu_req_gnt = '0;
    bank_ren    = '0;
    bank_addr   = '0;
    hit         = '0;
    win         = '0;
    ptr_d       = ptr_q;
    for (int b = 0; b < NUM_BANK; b++) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < NUM_LSU; i++) begin
          if (!hit[b] && lsu_req_vld[i] && lsu_req_bank[i*SEL_W +: SEL_W] == SEL_W'(b) &&
              (p == 1 || PTR_W'(i) >= ptr_q[b])) begin
            hit[b] = 1'b1;
            win[b] = PTR_W'(i);
            lsu_req_gnt[i] = !rst;
            bank_addr[b*ADDR_W +: ADDR_W] = rst ? '0 : lsu_req_addr[i*ADDR_W +: ADDR_W];
          end
        end
      end
      bank_ren[b] = hit[b] && !rst;
      ptr_d[b] = !hit[b] ? ptr_q[b] : (win[b] == PTR_W'(NUM_LSU-1)) ? '0 : win[b] + PTR_W'(1);
    end
  end

  // Newest stage sits at the bottom of each tracking vector, oldest at the top.
  always_comb begin
    rsp_vld_d  = '0;
    rsp_data_d = lsu_rsp_data;
    for (int b = 0; b < NUM_BANK; b++) begin
      pv_d[b]  = RD_LAT'({pv_q[b], bank_ren[b]});
      pid_d[b] = PID_W'({pid_q[b], win[b]});
    end
    for (int i = 0; i < NUM_LSU; i++) begin
      for (int b = 0; b < NUM_BANK; b++) begin
        if (pv_q[b][RD_LAT-1] && pid_q[b][PID_W-1 -: PTR_W] == PTR_W'(i)) begin
          rsp_vld_d[i] = 1'b1;
          rsp_data_d[i*DATA_W +: DATA_W] = bank_rdata[b*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      pv_q         <= '0;
      pid_q        <= '0;
      lsu_rsp_vld  <= '0;
      lsu_rsp_data <= '0;
    end else begin
      ptr_q        <= ptr_d;
      pv_q         <= pv_d;
      pid_q        <= pid_d;
      lsu_rsp_vld  <= rsp_vld_d;
      lsu_rsp_data <= rsp_data_d;
    end
  end
endmodule

// File: tb/tb_crossbar_rd_rr.sv
// tb_crossbar_rd_rr: three crossbar configurations driven by directed steps, responses checked via scoreboard
module tb_crossbar_rd_rr;
  localparam int NL = 8, DW = 32, AW = 10, SW = 3;
  localparam int LAT [3] = '{2, 1, 3};
  typedef struct {int k; int l; logic [DW-1:0] d; int due;} exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [2:0][NL-1:0] vld;
  logic [2:0][NL*SW-1:0] bnk;
  logic [2:0][NL*AW-1:0] adr;
  wire  [2:0][NL-1:0] gnt, rv;
  wire  [2:0][NL*DW-1:0] rd;
  wire  [2:0][7:0] ren;
  wire  [2:0][8*AW-1:0] baddr;
  logic [2:0][8*DW-1:0] rdata;
  wire  [5:0] ren2;
  wire  [6*AW-1:0] ba2;
  logic [2:0][7:0][3:0] pv = '0;
  logic [AW-1:0] pa [3][8][4];
  logic [NL-1:0] ev;
  int cyc = 0, nchk = 0, nerr = 0;
  bit mon_en = 1'b0;
  exp_t sb[$];

  assign ren[2]   = {2'b0, ren2};
  assign baddr[2] = {{(2*AW){1'b0}}, ba2};

  crossbar_rd_rr #(.RD_LAT(2)) u0 (.clk(clk), .rst(rst), .lsu_req_vld(vld[0]), .lsu_req_bank(bnk[0]),
    .lsu_req_addr(adr[0]), .lsu_req_gnt(gnt[0]), .bank_ren(ren[0]), .bank_addr(baddr[0]),
    .bank_rdata(rdata[0]), .lsu_rsp_vld(rv[0]), .lsu_rsp_data(rd[0]));
  crossbar_rd_rr #(.RD_LAT(1)) u1 (.clk(clk), .rst(rst), .lsu_req_vld(vld[1]), .lsu_req_bank(bnk[1]),
    .lsu_req_addr(adr[1]), .lsu_req_gnt(gnt[1]), .bank_ren(ren[1]), .bank_addr(baddr[1]),
    .bank_rdata(rdata[1]), .lsu_rsp_vld(rv[1]), .lsu_rsp_data(rd[1]));
  crossbar_rd_rr #(.NUM_BANK(6), .RD_LAT(3)) u2 (.clk(clk), .rst(rst), .lsu_req_vld(vld[2]),
    .lsu_req_bank(bnk[2]), .lsu_req_addr(adr[2]), .lsu_req_gnt(gnt[2]), .bank_ren(ren2),
    .bank_addr(ba2), .bank_rdata(rdata[2][6*DW-1:0]), .lsu_rsp_vld(rv[2]), .lsu_rsp_data(rd[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] fd(int k, int b, logic [AW-1:0] a);
    return {4'hD, 4'(k), 8'(b), 6'd0, a};
  endfunction

  // Bank memories: data is a pure function of bank and address, returned LAT cycles after ren.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      for (int b = 0; b < 8; b++) begin
        pv[k][b] <= {pv[k][b][2:0], ren[k][b]};
        pa[k][b][0] <= baddr[k][b*AW +: AW];
        for (int s = 1; s < 4; s++) pa[k][b][s] <= pa[k][b][s-1];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < 3; k++)
      for (int b = 0; b < 8; b++)
        rdata[k][b*DW +: DW] = pv[k][b][LAT[k]-1] ? fd(k, b, pa[k][b][LAT[k]-1]) : 32'hBAD0_0000;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        ev = '0;
        foreach (sb[i]) begin
          if (sb[i].k == k && sb[i].due == cyc) begin
            ev[sb[i].l] = 1'b1;
            nchk++;
            assert (rd[k][sb[i].l*DW +: DW] === sb[i].d)
              else begin nerr++; $error("FAIL rsp_data u%0d lsu%0d obs=%h exp=%h", k, sb[i].l, rd[k][sb[i].l*DW +: DW], sb[i].d); end
          end
        end
        nchk++;
        assert (rv[k] === ev)
          else begin nerr++; $error("FAIL rsp_vld u%0d cyc%0d obs=%b exp=%b", k, cyc, rv[k], ev); end
      end
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].due <= cyc) sb.delete(i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int k, int l, int b, int a);
    vld[k][l] = 1'b1;
    bnk[k][l*SW +: SW] = SW'(b);
    adr[k][l*AW +: AW] = AW'(a);
  endtask

  task automatic chk(string tag, int k, logic [NL-1:0] eg);
    logic [7:0] er;
    logic [8*AW-1:0] ea;
    int b;
    @(negedge clk);
    er = '0;
    ea = '0;
    for (int l = 0; l < NL; l++) begin
      if (eg[l]) begin
        b = int'(bnk[k][l*SW +: SW]);
        er[b] = 1'b1;
        ea[b*AW +: AW] = adr[k][l*AW +: AW];
        sb.push_back('{k, l, fd(k, b, adr[k][l*AW +: AW]), cyc + LAT[k] + 1});
      end
    end
    nchk++;
    assert (gnt[k] === eg) else begin nerr++; $error("FAIL %s gnt obs=%b exp=%b", tag, gnt[k], eg); end
    nchk++;
    assert (ren[k] === er) else begin nerr++; $error("FAIL %s ren obs=%b exp=%b", tag, ren[k], er); end
    nchk++;
    assert (baddr[k] === ea) else begin nerr++; $error("FAIL %s addr obs=%h exp=%h", tag, baddr[k], ea); end
  endtask

  initial begin
    vld = '0; bnk = '0; adr = '0;
    repeat (2) tick();
    drive(0, 0, 0, 1);
    chk("rst_gnt", 0, '0);
    for (int k = 0; k < 3; k++) begin
      nchk++;
      assert (rv[k] === '0 && rd[k] === '0)
        else begin nerr++; $error("FAIL rst_rsp u%0d obs=%b/%h exp=0", k, rv[k], rd[k]); end
    end
    tick(); rst = 1'b0; vld = '0; mon_en = 1'b1;
    tick(); drive(0, 3, 5, 'h12);
    chk("single", 0, 8'b0000_1000);
    tick(); vld = '0;
    repeat (4) tick();
    @(negedge clk);
    nchk++;
    assert (rd[0][3*DW +: DW] === fd(0, 5, 'h12))
      else begin nerr++; $error("FAIL hold obs=%h exp=%h", rd[0][3*DW +: DW], fd(0, 5, 'h12)); end
    tick();
    for (int l = 0; l < NL; l++) drive(0, l, 0, 'h40 + l);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("rr%0d", c), 0, 8'(1 << (c % NL)));
      tick();
    end
    vld = '0;
    repeat (4) tick();
    drive(0, 5, 2, 'h25);
    chk("wrap_a", 0, 8'b0010_0000);
    tick(); vld = '0; drive(0, 1, 2, 'h21); drive(0, 6, 2, 'h26);
    chk("wrap_b", 0, 8'b0100_0000);
    tick();
    chk("wrap_c", 0, 8'b0000_0010);
    tick(); vld = '0;
    repeat (4) tick();
    for (int l = 0; l < NL; l++) drive(1, l, 7 - l, 'h80 + l);
    chk("perm", 1, 8'hFF);
    tick(); vld = '0;
    repeat (3) tick();
    for (int c = 0; c < 4; c++) begin
      drive(2, 0, 1, c + 1);
      chk($sformatf("stream%0d", c), 2, 8'h01);
      tick();
    end
    vld = '0;
    repeat (6) tick();
    drive(2, 2, 7, 'h33); drive(2, 4, 6, 'h34);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("oor%0d", c), 2, '0);
      tick();
    end
    vld = '0;
    repeat (3) tick();
    drive(0, 4, 0, 'h44);
    chk("pre_rst", 0, 8'b0001_0000);
    tick(); vld = '0; rst = 1'b1; sb.delete();
    drive(0, 1, 0, 'h50);
    chk("mid_rst", 0, '0);
    tick(); rst = 1'b0; vld = '0; drive(0, 1, 0, 'h51); drive(0, 6, 0, 'h56);
    chk("post_rst", 0, 8'b0000_0010);
    nchk++;
    assert (rd[0] === '0) else begin nerr++; $error("FAIL post_rst_data obs=%h exp=0", rd[0]); end
    tick(); vld = '0;
    repeat (6) tick();
    nchk++;
    assert (sb.size() == 0) else begin nerr++; $error("FAIL sb_drain obs=%0d exp=0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/crossbar_rd_rr.md
# crossbar_rd_rr

Parametrised read crossbar between NUM_LSU load/store units and NUM_BANK memory bank groups. It supersedes the fixed 8x8, fixed-priority, purely combinational read select with three changes: per-bank round-robin arbitration with explicit grants, configurable bank read latency, and registered, in-order response return to the requesting LSU. It sits between the LSU array and the bank-group read ports in the overall design.

## Interface
Parameters:
- NUM_LSU, 8, number of LSU request ports (2..16)
- NUM_BANK, 8, number of bank groups (2..16, need not be a power of two)
- DATA_W, 32, read data width
- ADDR_W, 10, in-bank word address width
- RD_LAT, 1, bank read latency in cycles from bank_ren to valid bank_rdata (1..4)
- SEL_W, $clog2(NUM_BANK), bank select width (derived)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- lsu_req_vld  in  NUM_LSU  read request valid, one bit per LSU
- lsu_req_bank  in  NUM_LSU*SEL_W  target bank per LSU; LSU i at [i*SEL_W +: SEL_W]
- lsu_req_addr  in  NUM_LSU*ADDR_W  in-bank address per LSU
- lsu_req_gnt  out  NUM_LSU  request accepted this cycle (combinational)
- bank_ren  out  NUM_BANK  read enable per bank (combinational)
- bank_addr  out  NUM_BANK*ADDR_W  address of the granted request per bank; 0 when bank_ren is low
- bank_rdata  in  NUM_BANK*DATA_W  bank read data, valid RD_LAT cycles after bank_ren
- lsu_rsp_vld  out  NUM_LSU  response valid (registered)
- lsu_rsp_data  out  NUM_LSU*DATA_W  response data (registered)

## Operation
- Request: LSU i requests bank b when lsu_req_vld[i]=1 and lsu_req_bank[i]=b. An ungranted LSU holds vld, bank and addr stable until gnt. Dropping vld before gnt is legal; the request is withdrawn.
- Out-of-range select (lsu_req_bank >= NUM_BANK): the request is never granted and no bank access occurs.
- Arbitration: each bank has an independent round-robin arbiter with pointer ptr_b (log2 NUM_LSU bits).
  - Among the LSUs requesting bank b, the winner is the first index at or above ptr_b, wrapping modulo NUM_LSU.
  - On a grant to LSU i, ptr_b becomes (i+1) mod NUM_LSU. With no grant, ptr_b holds.
- Grant: lsu_req_gnt[i]=1 iff LSU i wins its bank. bank_ren[b]=1 iff bank b has a winner, and bank_addr[b] is the winner's address.
- Concurrency: every bank can grant in the same cycle, so a full permutation completes in one cycle. Each LSU receives at most one grant per cycle.
- Tracking: each bank has a RD_LAT-deep shift pipeline of {valid, lsu_id}, loaded with {bank_ren[b], winner} every cycle.
- Return: when a bank's final pipeline stage is valid with id i, bank_rdata[b] is registered into lsu_rsp_data[i] and lsu_rsp_vld[i] is set for one cycle.
  - An LSU can receive at most one return per cycle, because it holds at most one grant per cycle.
  - lsu_rsp_data holds its last value while lsu_rsp_vld is low.
- There is no backpressure on responses; the LSU must accept the response in the cycle it arrives.
- Reset: while rst=1, lsu_req_gnt, bank_ren and bank_addr are forced to 0. On the clock edge:
  - all ptr_b go to 0;
  - all pipeline valids clear;
  - lsu_rsp_vld and lsu_rsp_data go to 0.
- Reset mid-operation: in-flight reads are dropped and no response is issued for them.

## Timing
- Grant in cycle T (combinational from request and ptr).
- bank_ren and bank_addr asserted in cycle T.
- bank_rdata sampled in cycle T+RD_LAT.
- lsu_rsp_vld and lsu_rsp_data visible in cycle T+RD_LAT+1. Total latency is RD_LAT+1 cycles.
- Throughput: one read per bank per cycle; back-to-back grants to the same LSU return in grant order on consecutive cycles.
- Arbiter pointer update takes effect in cycle T+1.
- Reset values: lsu_req_gnt=0, bank_ren=0, bank_addr=0, lsu_rsp_vld=0, lsu_rsp_data=0, ptr_b=0.

## Test plan
- Single read, RD_LAT=2: LSU3 requests bank 5, addr 0x12, at T; bank returns 0xDEADBEEF at T+2.
  - Required: gnt[3] and bank_ren[5] with addr 0x12 at T; lsu_rsp_vld[3]=1 with data 0xDEADBEEF at T+3; no other rsp_vld.
- Round-robin fairness: after reset, all 8 LSUs hold a request to bank 0 continuously.
  - Required: grants go to 0,1,2,...,7,0,1 on consecutive cycles, each LSU exactly once per 8 cycles.
- Pointer wrap: grant LSU5 on bank 2, then LSUs 1 and 6 request bank 2.
  - Required: LSU6 is granted first, LSU1 next cycle.
- Permutation, RD_LAT=1: LSU i requests bank 7-i; bank b returns data 0xB0+b.
  - Required: all 8 granted in one cycle; LSU i receives 0xB0+(7-i) one cycle after the return.
- Pipelined stream, RD_LAT=3: LSU0 reads bank 1 on 4 consecutive cycles; the bank returns 0x1..0x4.
  - Required: lsu_rsp_vld[0] high for 4 consecutive cycles starting at grant+4, with data 0x1,0x2,0x3,0x4 in order.
- Reset and out-of-range:
  - rst asserted one cycle after a grant: no response is issued and the next arbitration starts from ptr=0.
  - With NUM_BANK=6, a request to bank 7: gnt stays 0 indefinitely and bank_ren stays 0.
